// File: rtl/alarm_bank.sv
// Alarm store with user edit controls and a timed ring output.
// Holds NUM_ALARMS hour/minute/enable entries and rings when one matches on a minute change.
module alarm_bank #(
    parameter int NUM_ALARMS  = 4,
    parameter int SEL_W       = 2,
    parameter int HOUR_MAX    = 23,
    parameter int MIN_MAX     = 59,
    parameter int RING_CYCLES = 50000,
    parameter int RING_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       hour,
    input  logic [7:0]       minute,
    input  logic [1:0]       mode,
    input  logic             turn,
    input  logic             change,
    input  logic [SEL_W-1:0] sel,
    input  logic             stop,
    output logic [7:0]       hour_keep,
    output logic [7:0]       minute_keep,
    output logic             enabled,
    output logic             ring,
    output logic [SEL_W-1:0] ring_id
);

    typedef enum logic {
        IDLE    = 1'b0,
        RINGING = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [RING_W-1:0]   timer_reg, timer_next;
    logic [SEL_W-1:0]    ring_id_reg, ring_id_next;

    logic                change_meta_reg;
    logic                change_sync_reg;
    logic                change_prev_reg;
    logic                edit_event;
    logic [7:0]          minute_d_reg;
    logic                minute_tick;

    logic [7:0]          alarm_hour [NUM_ALARMS];
    logic [7:0]          alarm_min  [NUM_ALARMS];
    logic                alarm_en   [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] match;

    logic                win_any;
    logic [SEL_W-1:0]    win_idx;

    // change is asynchronous: two-flop synchroniser followed by a rising-edge detector
    always_ff @(posedge clk) begin
        if (rst) begin
            change_meta_reg <= 1'b0;
            change_sync_reg <= 1'b0;
            change_prev_reg <= 1'b0;
        end else begin
            change_meta_reg <= change;
            change_sync_reg <= change_meta_reg;
            change_prev_reg <= change_sync_reg;
        end
    end

    assign edit_event = change_sync_reg & ~change_prev_reg;

    // Loaded with the live minute during reset as well, so leaving reset never fakes a tick
    always_ff @(posedge clk) begin
        minute_d_reg <= minute;
    end

    assign minute_tick = (minute != minute_d_reg);

    generate
        for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_alarm
            logic [7:0] hour_reg;
            logic [7:0] min_reg;
            logic       en_reg;
            logic       edit_hit;

            assign edit_hit = edit_event && (sel == SEL_W'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    hour_reg <= 8'd0;
                    min_reg  <= 8'd0;
                    en_reg   <= 1'b0;
                end else if (edit_hit) begin
                    if (mode == 2'd2) begin
                        if (turn) begin
                            hour_reg <= (hour_reg == 8'(HOUR_MAX)) ? 8'd0 : hour_reg + 8'd1;
                        end else begin
                            min_reg <= (min_reg == 8'(MIN_MAX)) ? 8'd0 : min_reg + 8'd1;
                        end
                    end else if (mode == 2'd3) begin
                        en_reg <= ~en_reg;
                    end
                end
            end

            assign alarm_hour[gi] = hour_reg;
            assign alarm_min[gi]  = min_reg;
            assign alarm_en[gi]   = en_reg;
            assign match[gi]      = minute_tick && en_reg &&
                                    (hour == hour_reg) && (minute == min_reg);
        end
    endgenerate

    // Selected-channel read for the display; unpopulated select codes read as zero
    always_comb begin
        hour_keep   = 8'd0;
        minute_keep = 8'd0;
        enabled     = 1'b0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (sel == SEL_W'(i)) begin
                hour_keep   = alarm_hour[i];
                minute_keep = alarm_min[i];
                enabled     = alarm_en[i];
            end
        end
    end

    // Lowest-index matching channel wins
    always_comb begin
        win_any = |match;
        win_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (match[i]) begin
                win_idx = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            timer_reg   <= '0;
            ring_id_reg <= '0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            ring_id_reg <= ring_id_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg;
        ring_id_next = ring_id_reg;
        case (state_reg)
            IDLE: begin
                if (win_any) begin
                    state_next   = RINGING;
                    ring_id_next = win_idx;
                    timer_next   = RING_W'(RING_CYCLES - 1);
                end
            end
            RINGING: begin
                // New matches are ignored while ringing; stop beats timeout
                if (stop || (timer_reg == '0)) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    assign ring    = (state_reg == RINGING);
    assign ring_id = ring_id_reg;

endmodule

// File: tb/tb_alarm_bank.sv
// Scoreboarded bench for alarm_bank: a cycle-level reference model pushes expectations,
// a monitor pops and compares them one clock later.
module tb_alarm_bank;

    localparam int NA = 4;
    localparam int RC = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] hour, minute;
    logic [1:0] mode;
    logic       turn, change, stop;
    logic [1:0] sel;
    logic [7:0] hour_keep, minute_keep;
    logic       enabled, ring;
    logic [1:0] ring_id;

    alarm_bank #(
        .NUM_ALARMS(NA), .SEL_W(2), .HOUR_MAX(23), .MIN_MAX(59),
        .RING_CYCLES(RC), .RING_W(16)
    ) dut (
        .clk(clk), .rst(rst), .hour(hour), .minute(minute), .mode(mode),
        .turn(turn), .change(change), .sel(sel), .stop(stop),
        .hour_keep(hour_keep), .minute_keep(minute_keep), .enabled(enabled),
        .ring(ring), .ring_id(ring_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ring;
        int id;
        int hk;
        int mk;
        int en;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 0;

    // Reference model state: alarms as plain integers, change history as pin samples
    int m_hour[NA];
    int m_min[NA];
    int m_en[NA];
    int m_ring, m_id, m_left, m_prev_min;
    int m_smp[3];   // change level sampled 1, 2, 3 edges ago

    task automatic model_edge();
        int win;
        bit edit, tick;
        exp_t e;
        if (rst) begin
            for (int i = 0; i < NA; i++) begin
                m_hour[i] = 0; m_min[i] = 0; m_en[i] = 0;
            end
            m_ring = 0; m_id = 0; m_left = 0;
            m_smp[0] = 0; m_smp[1] = 0; m_smp[2] = 0;
            m_prev_min = int'(minute);
        end else begin
            // An edit fires two edges after change is first seen high
            edit = (m_smp[1] == 1) && (m_smp[2] == 0);
            tick = (int'(minute) != m_prev_min);
            win = -1;
            if (tick) begin
                for (int i = 0; i < NA; i++) begin
                    if (win < 0 && m_en[i] == 1 && m_hour[i] == int'(hour) && m_min[i] == int'(minute))
                        win = i;
                end
            end
            if (m_ring == 1) begin
                if (stop) m_ring = 0;
                else begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_ring = 0;
                end
            end else if (win >= 0) begin
                m_ring = 1; m_id = win; m_left = RC;
            end
            if (edit && int'(sel) < NA) begin
                if (mode == 2'd2 && turn)  m_hour[sel] = (m_hour[sel] + 1) % 24;
                if (mode == 2'd2 && !turn) m_min[sel]  = (m_min[sel] + 1) % 60;
                if (mode == 2'd3)          m_en[sel]   = 1 - m_en[sel];
            end
            m_smp[2] = m_smp[1]; m_smp[1] = m_smp[0]; m_smp[0] = int'(change);
            m_prev_min = int'(minute);
        end
        e.ring = m_ring; e.id = m_id;
        e.hk = m_hour[sel]; e.mk = m_min[sel]; e.en = m_en[sel];
        expq.push_back(e);
    endtask

    // Inputs are already set; predict the coming edge, then wait for the next falling edge
    task automatic step();
        model_edge();
        @(negedge clk);
    endtask

    task automatic pulse(input logic [1:0] md, input logic tn, input logic [1:0] s, input int n);
        mode = md; turn = tn; sel = s;
        for (int k = 0; k < n; k++) begin
            change = 1'b1; step(); step();
            change = 1'b0; step(); step();
        end
        $display("edit mode=%0d turn=%0d sel=%0d pulses=%0d keep=%0d:%0d en=%0d",
                 md, tn, s, n, m_hour[s], m_min[s], m_en[s]);
    endtask

    task automatic set_time(input int h, input int m, input int cyc);
        hour = 8'(h); minute = 8'(m);
        repeat (cyc) step();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        int   last_ring = 0;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() == 0) begin
                if (!done) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_empty actual=0 expected=1 at %0t", $time);
                end
            end else begin
                e = expq.pop_front();
                chk("ring", int'(ring), e.ring);
                chk("ring_id", int'(ring_id), e.id);
                chk("hour_keep", int'(hour_keep), e.hk);
                chk("minute_keep", int'(minute_keep), e.mk);
                chk("enabled", int'(enabled), e.en);
                if (e.ring == 1 && last_ring == 0)
                    $display("ring start id=%0d time=%0d:%0d at %0t", e.id, hour, minute, $time);
                last_ring = e.ring;
            end
        end
    end

    initial begin : driver
        rst = 1'b1; hour = 8'd0; minute = 8'd0; mode = 2'd0; turn = 1'b0;
        change = 1'b0; sel = 2'd0; stop = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Hour edits on channel 1, then wrap boundaries on channel 0
        pulse(2'd2, 1'b1, 2'd1, 5);
        sel = 2'd0; step();
        pulse(2'd2, 1'b0, 2'd0, 59);
        pulse(2'd2, 1'b0, 2'd0, 1);
        pulse(2'd2, 1'b1, 2'd0, 23);
        pulse(2'd2, 1'b1, 2'd0, 1);
        change = 1'b1; repeat (100) step();
        change = 1'b0; repeat (4) step();

        // Channel 2 at 07:30, enabled; ring runs to timeout
        pulse(2'd2, 1'b1, 2'd2, 7);
        pulse(2'd2, 1'b0, 2'd2, 30);
        pulse(2'd3, 1'b0, 2'd2, 1);
        mode = 2'd0;
        set_time(7, 29, 3);
        set_time(7, 30, 14);

        // Channels 1 and 3 both at 06:00; lowest wins, stop on third ring cycle
        pulse(2'd2, 1'b1, 2'd1, 1);
        pulse(2'd2, 1'b1, 2'd3, 6);
        pulse(2'd3, 1'b0, 2'd1, 1);
        pulse(2'd3, 1'b0, 2'd3, 1);
        mode = 2'd0;
        set_time(5, 59, 3);
        set_time(6, 0, 3);
        stop = 1'b1; step();
        stop = 1'b0; repeat (4) step();

        // Editing onto the current time does not ring; disabled alarm never rings
        set_time(12, 0, 3);
        pulse(2'd3, 1'b0, 2'd0, 1);
        pulse(2'd2, 1'b1, 2'd0, 12);
        mode = 2'd0; repeat (4) step();
        pulse(2'd3, 1'b0, 2'd0, 1);
        mode = 2'd0;
        set_time(12, 1, 2);
        set_time(12, 0, 4);

        // Reset mid-ring, then a matching tick with everything disabled
        set_time(7, 29, 3);
        set_time(7, 30, 3);
        rst = 1'b1; step();
        rst = 1'b0;
        set_time(7, 29, 3);
        set_time(7, 30, 4);

        // Random phase around a few nearby alarm times
        pulse(2'd2, 1'b0, 2'd0, 1);
        pulse(2'd2, 1'b0, 2'd1, 2);
        pulse(2'd2, 1'b1, 2'd2, 1);
        pulse(2'd2, 1'b0, 2'd2, 1);
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 3) == 0) change = ~change;
            if ($urandom_range(0, 15) == 0) mode = 2'd2;
            else mode = ($urandom_range(0, 2) == 2) ? 2'd3 : 2'($urandom_range(0, 1));
            turn = 1'($urandom_range(0, 1));
            sel  = 2'($urandom_range(0, 3));
            stop = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 5) == 0) begin
                hour   = 8'($urandom_range(0, 1));
                minute = 8'($urandom_range(0, 2));
            end
            step();
        end
        rst = 1'b0; stop = 1'b0;
        step();

        done = 1;
        @(posedge clk);
        #2;
        chk("scoreboard_drained", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_bank.md
Name: alarm_bank

Overview:
- Multi-channel alarm store and trigger. Holds NUM_ALARMS alarm times, edited through the mode/turn/change user controls.
- Each alarm time is compared against the running hour/minute from the timekeeping counter. Drives a timed ring output with a stop control.
- Sits between the clock counter and the buzzer/display mux. Its selected-alarm outputs feed the display in alarm-set mode.

Parameters:
NUM_ALARMS, 4, number of independent alarm channels (1..16)
SEL_W, 2, width of alarm select and ring_id (must satisfy 2**SEL_W >= NUM_ALARMS)
HOUR_MAX, 23, highest legal hour; hour increment wraps HOUR_MAX -> 0
MIN_MAX, 59, highest legal minute; minute increment wraps MIN_MAX -> 0
RING_CYCLES, 50000, clk cycles ring stays asserted if not stopped (>= 1)
RING_W, 16, width of ring timer (must hold RING_CYCLES)

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  synchronous, active-high reset
hour  in  8  current hour, binary 0..HOUR_MAX
minute  in  8  current minute, binary 0..MIN_MAX
mode  in  2  2 = alarm time edit, 3 = alarm enable edit, other = run
turn  in  1  in mode 2: 1 edits hour, 0 edits minute
change  in  1  user increment/toggle level, asynchronous to clk
sel  in  SEL_W  alarm channel addressed by edits and by the keep outputs
stop  in  1  level; silences an active ring
hour_keep  out  8  hour of alarm[sel]
minute_keep  out  8  minute of alarm[sel]
enabled  out  1  enable bit of alarm[sel]
ring  out  1  alarm ringing
ring_id  out  SEL_W  channel that caused the current/last ring

Behaviour:
Reset:
- All alarm hours and minutes = 0 and all enables = 0.
- ring = 0, ring_id = 0, ring timer = 0, FSM = IDLE.
- Synchronisers and history registers are cleared (change history = 0; minute history loaded with the current minute input, so reset never creates a minute edge).

Change input handling:
- change passes through a 2-flop synchroniser, then a rising-edge detector.
- One detected edge = exactly one edit event. Holding change high gives one event only.
- An edit event with sel >= NUM_ALARMS is ignored.

Edit events:
- mode 2, turn=1: hour[sel] <= (hour[sel] == HOUR_MAX) ? 0 : hour[sel]+1.
- mode 2, turn=0: minute[sel] <= (minute[sel] == MIN_MAX) ? 0 : minute[sel]+1.
- mode 3: enable[sel] toggles.
- mode 0/1: edit events have no effect.
- The edit takes effect on the edge-detect cycle. Latency from change rising at the pin to the keep output updating is 3 clk.

Keep outputs:
- Combinational read of alarm[sel]. For sel >= NUM_ALARMS they read 0.

Trigger:
- minute_tick = (minute != minute_d), where minute_d is minute registered one cycle.
- On a minute_tick cycle, channel i matches when enable[i] && hour == hour[i] && minute == minute[i].
- Editing an alarm onto the current time does not ring until the next matching tick.
- If several channels match, the lowest index wins.

FSM:
- IDLE: on a match, go to RINGING next cycle; ring=1, ring_id = winner, timer = RING_CYCLES-1.
- RINGING, stop=1: go to IDLE; ring=0 next cycle. stop has priority over timeout.
- RINGING, timer == 0: go to IDLE; ring=0. Otherwise timer decrements. Total ring length = RING_CYCLES cycles.
- RINGING, new match: ignored; ring_id unchanged and timer not restarted.
- IDLE: stop has no effect.

Other boundary conditions:
- Disabling the ringing channel via mode 3 does not stop an active ring.
- Reset while RINGING drops ring on the next clk edge.
- ring_id holds its value after the ring ends, until the next trigger.

Test Plan:
- Reset, then sel=1, mode=2, turn=1, five change pulses -> hour_keep=5; other channels still 0; each pulse updates the output 3 clk after change rises.
- sel=0, mode=2, turn=0, alarm minute at 59, one change pulse -> minute_keep=0; hour at 23 plus one pulse -> hour_keep=0. Change held high for 100 cycles -> a single increment.
- Alarm 2 set to 07:30, mode 3 toggles it enabled; drive hour/minute 07:29 -> 07:30 -> ring=1 one cycle after the minute changes, ring_id=2. With RING_CYCLES=8 and no stop -> ring high exactly 8 cycles.
- Alarms 1 and 3 both 06:00 and enabled; time reaches 06:00 -> ring_id=1. Pulse stop at cycle 3 of the ring -> ring=0 next cycle.
- Time already 12:00; edit an enabled alarm to 12:00 -> no ring. Alarm disabled, time reaches its value -> no ring.
- rst asserted mid-ring -> ring=0, all keep outputs 0, enabled=0 after one clk; the following minute tick with matching time -> no ring, since all alarms are disabled.
